// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle RV32I control path.
// Contents: opcode constants, ALUOp / pc_src / MemtoReg encodings,
// the controller state enum, the instruction-class enum and a branch
// condition helper used by the controller.
package rv_defs;

    // Base opcodes recognised by the controller (IR[6:0])
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Branch sense from Funct3
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // ALUOp encodings consumed by the ALUController
    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_PC4 = 2'b00;
    localparam logic [1:0] PCSRC_TGT = 2'b01;
    localparam logic [1:0] PCSRC_ALU = 2'b10;

    // Register-file write-back source select
    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CL_NOP    = 3'd0,
        CL_R      = 3'd1,
        CL_I      = 3'd2,
        CL_LOAD   = 3'd3,
        CL_STORE  = 3'd4,
        CL_BRANCH = 3'd5,
        CL_JAL    = 3'd6,
        CL_JALR   = 3'd7
    } class_e;

    // Branch condition: BEQ taken on zero, BNE on !zero, anything else not taken
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        logic taken;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Shared instruction/data memory handshake.
//   mem_req      controller -> memory  request active
//   mem_we       controller -> memory  1 = store
//   mem_addr_sel controller -> memory  0 = PC, 1 = ALU result
//   mem_ready    memory -> controller  request completes this cycle
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_controller_opcode_classifier.sv
// Combinational opcode decoder.
//   opcode   in  7  IR[6:0]
//   op_class out    instruction class (CL_NOP when unrecognised)
//   valid    out 1  opcode is one of the supported base opcodes
module opcode_classifier
    import rv_defs::*;
(
    input  logic [6:0] opcode,
    output class_e     op_class,
    output logic       valid
);

    // Map opcode to class; unknown opcodes report invalid and class NOP
    always_comb begin
        op_class = CL_NOP;
        valid    = 1'b0;
        case (opcode)
            OPC_R:      begin op_class = CL_R;      valid = 1'b1; end
            OPC_I_ALU:  begin op_class = CL_I;      valid = 1'b1; end
            OPC_LOAD:   begin op_class = CL_LOAD;   valid = 1'b1; end
            OPC_STORE:  begin op_class = CL_STORE;  valid = 1'b1; end
            OPC_BRANCH: begin op_class = CL_BRANCH; valid = 1'b1; end
            OPC_JAL:    begin op_class = CL_JAL;    valid = 1'b1; end
            OPC_JALR:   begin op_class = CL_JALR;   valid = 1'b1; end
            default:    begin op_class = CL_NOP;    valid = 1'b0; end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RV32I core: sequences FETCH/DECODE/EXEC/
// MEM/WB around a single shared memory and counts retired instructions.
// Ports:
//   clk, reset (async, active-low)
//   mem          memory handshake (master side)
//   Opcode, Funct3, zero          instruction fields / ALU flag
//   ir_we, pc_we, pc_src, ALUSrc, ALUOp, RegWrite, MemtoReg   datapath strobes
//   retire       one-cycle pulse per completed instruction
//   instr_count  retired-instruction counter (wraps)
//   illegal      sticky flag, set when the FSM enters TRAP
// Strobes are combinational from state/class/mem_ready/zero and are held
// low while reset is asserted so an aborted instruction writes nothing.
module multicycle_controller
    import rv_defs::*;
#(
    parameter int CNT_W        = 32,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_controller_if.master   mem,
    input  logic [6:0]                Opcode,
    input  logic [2:0]                Funct3,
    input  logic                      zero,
    output logic                      ir_we,
    output logic                      pc_we,
    output logic [1:0]                pc_src,
    output logic                      ALUSrc,
    output logic [1:0]                ALUOp,
    output logic                      RegWrite,
    output logic [1:0]                MemtoReg,
    output logic                      retire,
    output logic [CNT_W-1:0]          instr_count,
    output logic                      illegal
);

    state_e           state_r, state_s;
    class_e           class_r, class_s;
    class_e           dec_class_s;
    logic             dec_valid_s;
    logic [CNT_W-1:0] count_r;
    logic             illegal_r;

    logic       mem_req_s, mem_we_s, mem_addr_sel_s;
    logic       ir_we_s, pc_we_s, alusrc_s, regwrite_s, retire_s;
    logic [1:0] pc_src_s, aluop_s, memtoreg_s;

    opcode_classifier u_classifier (
        .opcode   (Opcode),
        .op_class (dec_class_s),
        .valid    (dec_valid_s)
    );

    // Next-state and strobe decode; everything defaults to idle/hold
    always_comb begin
        state_s        = state_r;
        class_s        = class_r;
        mem_req_s      = 1'b0;
        mem_we_s       = 1'b0;
        mem_addr_sel_s = 1'b0;
        ir_we_s        = 1'b0;
        pc_we_s        = 1'b0;
        pc_src_s       = PCSRC_PC4;
        alusrc_s       = 1'b0;
        aluop_s        = ALUOP_ADD;
        regwrite_s     = 1'b0;
        memtoreg_s     = M2R_ALU;
        retire_s       = 1'b0;
        if (!reset) begin
            // Registers are being cleared asynchronously; keep every strobe low
            state_s = FETCH;
            class_s = CL_NOP;
        end else begin
            case (state_r)
                FETCH: begin
                    mem_req_s = 1'b1;
                    if (mem.mem_ready) begin
                        ir_we_s = 1'b1;
                        state_s = DECODE;
                    end else begin
                        state_s = FETCH;
                    end
                end
                DECODE: begin
                    class_s = dec_class_s;
                    if (dec_valid_s) begin
                        state_s = EXEC;
                    end else if (ILLEGAL_TRAP) begin
                        state_s = TRAP;
                    end else begin
                        // Unknown opcode retires as a NOP: PC+4 only
                        pc_we_s  = 1'b1;
                        retire_s = 1'b1;
                        state_s  = FETCH;
                    end
                end
                EXEC: begin
                    case (class_r)
                        CL_R: begin
                            aluop_s = ALUOP_FN;
                            state_s = WB;
                        end
                        CL_I: begin
                            aluop_s  = ALUOP_FN;
                            alusrc_s = 1'b1;
                            state_s  = WB;
                        end
                        CL_LOAD, CL_STORE: begin
                            alusrc_s = 1'b1;
                            state_s  = MEM;
                        end
                        CL_BRANCH: begin
                            aluop_s  = ALUOP_BR;
                            pc_we_s  = 1'b1;
                            pc_src_s = branch_taken(Funct3, zero) ? PCSRC_TGT : PCSRC_PC4;
                            retire_s = 1'b1;
                            state_s  = FETCH;
                        end
                        CL_JAL: begin
                            regwrite_s = 1'b1;
                            memtoreg_s = M2R_PC4;
                            pc_we_s    = 1'b1;
                            pc_src_s   = PCSRC_TGT;
                            retire_s   = 1'b1;
                            state_s    = FETCH;
                        end
                        CL_JALR: begin
                            alusrc_s   = 1'b1;
                            regwrite_s = 1'b1;
                            memtoreg_s = M2R_PC4;
                            pc_we_s    = 1'b1;
                            pc_src_s   = PCSRC_ALU;
                            retire_s   = 1'b1;
                            state_s    = FETCH;
                        end
                        default: begin
                            state_s = FETCH;
                        end
                    endcase
                end
                MEM: begin
                    // Request and its qualifiers stay stable until mem_ready
                    mem_req_s      = 1'b1;
                    mem_addr_sel_s = 1'b1;
                    mem_we_s       = (class_r == CL_STORE);
                    if (mem.mem_ready) begin
                        if (class_r == CL_STORE) begin
                            pc_we_s  = 1'b1;
                            retire_s = 1'b1;
                            state_s  = FETCH;
                        end else begin
                            state_s = WB;
                        end
                    end else begin
                        state_s = MEM;
                    end
                end
                WB: begin
                    regwrite_s = 1'b1;
                    memtoreg_s = (class_r == CL_LOAD) ? M2R_MEM : M2R_ALU;
                    pc_we_s    = 1'b1;
                    retire_s   = 1'b1;
                    state_s    = FETCH;
                end
                TRAP: begin
                    state_s = TRAP;
                end
                default: begin
                    state_s = FETCH;
                end
            endcase
        end
    end

    // State, class, retired counter and sticky illegal flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= FETCH;
            class_r   <= CL_NOP;
            count_r   <= {CNT_W{1'b0}};
            illegal_r <= 1'b0;
        end else begin
            state_r <= state_s;
            class_r <= class_s;
            if (retire_s) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                count_r <= count_r;
            end
            illegal_r <= illegal_r | (state_s == TRAP);
        end
    end

    assign mem.mem_req      = mem_req_s;
    assign mem.mem_we       = mem_we_s;
    assign mem.mem_addr_sel = mem_addr_sel_s;
    assign ir_we            = ir_we_s;
    assign pc_we            = pc_we_s;
    assign pc_src           = pc_src_s;
    assign ALUSrc           = alusrc_s;
    assign ALUOp            = aluop_s;
    assign RegWrite         = regwrite_s;
    assign MemtoReg         = memtoreg_s;
    assign retire           = retire_s;
    assign instr_count      = count_r;
    assign illegal          = illegal_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. dut1: CNT_W=4, ILLEGAL_TRAP=1;
// dut2: CNT_W=32, ILLEGAL_TRAP=0, driven by the same stimulus.
// Strobes are packed as {mem_req, mem_we, mem_addr_sel, ir_we, pc_we,
// pc_src[1:0], ALUSrc, ALUOp[1:0], RegWrite, MemtoReg[1:0], retire}.
module tb_multicycle_controller;

    localparam logic [13:0] REQ     = 14'h2000;
    localparam logic [13:0] WE      = 14'h1000;
    localparam logic [13:0] ASEL    = 14'h0800;
    localparam logic [13:0] IRWE    = 14'h0400;
    localparam logic [13:0] PCWE    = 14'h0200;
    localparam logic [13:0] PCS_TGT = 14'h0080;
    localparam logic [13:0] PCS_ALU = 14'h0100;
    localparam logic [13:0] ALUSRC  = 14'h0040;
    localparam logic [13:0] OP_BR   = 14'h0010;
    localparam logic [13:0] OP_FN   = 14'h0020;
    localparam logic [13:0] RW      = 14'h0008;
    localparam logic [13:0] M2R_MEM = 14'h0002;
    localparam logic [13:0] M2R_PC  = 14'h0004;
    localparam logic [13:0] RET     = 14'h0001;
    localparam logic [13:0] NONE    = 14'h0000;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        z;
        int          fw;     // fetch wait cycles
        int          mw;     // MEM wait cycles
        logic        noise;  // drive mem_ready high on cycles without a request
        logic [13:0] ex;     // EXEC strobes
        logic [13:0] mm;     // MEM strobes while waiting (NONE: no MEM phase)
        logic [13:0] mmd;    // MEM strobes on the ready cycle
        logic [13:0] wb;     // WB strobes (NONE: no WB phase)
    } vec_t;

    typedef struct {
        logic [13:0] s;
        logic [3:0]  cnt;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        zero;

    logic        ir_we1, pc_we1, alusrc1, regw1, retire1, ill1;
    logic [1:0]  pc_src1, aluop1, m2r1;
    logic [3:0]  cnt1;
    logic        ir_we2, pc_we2, alusrc2, regw2, retire2, ill2;
    logic [1:0]  pc_src2, aluop2, m2r2;
    logic [31:0] cnt2;
    logic [13:0] st1, st2;

    int   checks;
    int   failures;
    logic [3:0] mcount;
    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[12];

    multicycle_controller_if mif1 ();
    multicycle_controller_if mif2 ();

    multicycle_controller #(.CNT_W(4), .ILLEGAL_TRAP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .mem(mif1.master),
        .Opcode(opcode), .Funct3(funct3), .zero(zero),
        .ir_we(ir_we1), .pc_we(pc_we1), .pc_src(pc_src1), .ALUSrc(alusrc1),
        .ALUOp(aluop1), .RegWrite(regw1), .MemtoReg(m2r1), .retire(retire1),
        .instr_count(cnt1), .illegal(ill1)
    );

    multicycle_controller #(.CNT_W(32), .ILLEGAL_TRAP(1'b0)) dut2 (
        .clk(clk), .reset(reset), .mem(mif2.master),
        .Opcode(opcode), .Funct3(funct3), .zero(zero),
        .ir_we(ir_we2), .pc_we(pc_we2), .pc_src(pc_src2), .ALUSrc(alusrc2),
        .ALUOp(aluop2), .RegWrite(regw2), .MemtoReg(m2r2), .retire(retire2),
        .instr_count(cnt2), .illegal(ill2)
    );

    assign st1 = {mif1.mem_req, mif1.mem_we, mif1.mem_addr_sel, ir_we1, pc_we1,
                  pc_src1, alusrc1, aluop1, regw1, m2r1, retire1};
    assign st2 = {mif2.mem_req, mif2.mem_we, mif2.mem_addr_sel, ir_we2, pc_we2,
                  pc_src2, alusrc2, aluop2, regw2, m2r2, retire2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: compares dut1 against the expectation for this cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("strobes", {18'd0, st1}, {18'd0, mon_e.s});
            chk("instr_count", {28'd0, cnt1}, {28'd0, mon_e.cnt});
            chk("illegal", {31'd0, ill1}, {31'd0, mon_e.ill});
        end
    end

    task automatic set_ready(input logic r);
        mif1.mem_ready = r;
        mif2.mem_ready = r;
    endtask

    // One clock cycle: drive mem_ready, queue the expectation, advance
    task automatic step(input logic [13:0] s, input logic rdy, input logic ill);
        exp_t e;
        set_ready(rdy);
        e.s   = s;
        e.cnt = mcount;
        e.ill = ill;
        sb.push_back(e);
        @(negedge clk);
        @(posedge clk);
        #1;
        if (s[0]) mcount = mcount + 4'd1;
    endtask

    task automatic run_vec(input vec_t v);
        opcode = v.opc;
        funct3 = v.f3;
        zero   = v.z;
        for (int i = 0; i < v.fw; i++) step(REQ, 1'b0, 1'b0);
        step(REQ | IRWE, 1'b1, 1'b0);
        step(NONE, v.noise, 1'b0);
        step(v.ex, v.noise, 1'b0);
        if (v.mm != NONE) begin
            for (int i = 0; i < v.mw; i++) step(v.mm, 1'b0, 1'b0);
            step(v.mmd, 1'b1, 1'b0);
        end
        if (v.wb != NONE) step(v.wb, v.noise, 1'b0);
    endtask

    // Assert reset mid-cycle, check strobes drop at once, release after an edge
    task automatic do_reset();
        set_ready(1'b0);
        #2 reset = 1'b0;
        #1;
        chk("rst_strobes_dut1", {18'd0, st1}, 32'd0);
        chk("rst_strobes_dut2", {18'd0, st2}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_count", {28'd0, cnt1}, 32'd0);
        chk("rst_illegal", {31'd0, ill1}, 32'd0);
        reset  = 1'b1;
        mcount = 4'd0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mcount   = 4'd0;
        reset    = 1'b0;
        opcode   = 7'd0;
        funct3   = 3'd0;
        zero     = 1'b0;
        set_ready(1'b0);

        //            opc          f3      z     fw mw noise  ex                                   mm                mmd                           wb
        tbl[0]  = '{7'b0110011, 3'b000, 1'b0, 0, 0, 1'b0, OP_FN,                               NONE,             NONE,                         RW | PCWE | RET};
        tbl[1]  = '{7'b0010011, 3'b000, 1'b0, 2, 0, 1'b1, OP_FN | ALUSRC,                      NONE,             NONE,                         RW | PCWE | RET};
        tbl[2]  = '{7'b0000011, 3'b010, 1'b0, 0, 3, 1'b0, ALUSRC,                              REQ | ASEL,       REQ | ASEL,                   RW | M2R_MEM | PCWE | RET};
        tbl[3]  = '{7'b0100011, 3'b010, 1'b0, 1, 1, 1'b1, ALUSRC,                              REQ | ASEL | WE,  REQ | ASEL | WE | PCWE | RET, NONE};
        tbl[4]  = '{7'b1100011, 3'b000, 1'b1, 0, 0, 1'b0, OP_BR | PCWE | PCS_TGT | RET,        NONE,             NONE,                         NONE};
        tbl[5]  = '{7'b1100011, 3'b001, 1'b1, 0, 0, 1'b0, OP_BR | PCWE | RET,                  NONE,             NONE,                         NONE};
        tbl[6]  = '{7'b1100011, 3'b000, 1'b0, 0, 0, 1'b1, OP_BR | PCWE | RET,                  NONE,             NONE,                         NONE};
        tbl[7]  = '{7'b1100011, 3'b001, 1'b0, 1, 0, 1'b0, OP_BR | PCWE | PCS_TGT | RET,        NONE,             NONE,                         NONE};
        tbl[8]  = '{7'b1100011, 3'b100, 1'b1, 0, 0, 1'b0, OP_BR | PCWE | RET,                  NONE,             NONE,                         NONE};
        tbl[9]  = '{7'b1101111, 3'b000, 1'b0, 0, 0, 1'b1, RW | M2R_PC | PCWE | PCS_TGT | RET,  NONE,             NONE,                         NONE};
        tbl[10] = '{7'b1100111, 3'b000, 1'b0, 0, 0, 1'b0, ALUSRC | RW | M2R_PC | PCWE | PCS_ALU | RET, NONE,    NONE,                         NONE};
        tbl[11] = '{7'b0000011, 3'b010, 1'b0, 0, 0, 1'b1, ALUSRC,                              REQ | ASEL,       REQ | ASEL,                   RW | M2R_MEM | PCWE | RET};

        @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset while FETCH is requesting, then FETCH with a clean counter
        step(REQ, 1'b0, 1'b0);
        do_reset();
        step(REQ, 1'b0, 1'b0);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Unknown opcode: dut1 traps, dut2 retires it as a NOP
        do_reset();
        opcode = 7'b1111111;
        set_ready(1'b1);
        @(negedge clk);
        chk("ill_fetch_dut1", {18'd0, st1}, {18'd0, REQ | IRWE});
        chk("ill_fetch_dut2", {18'd0, st2}, {18'd0, REQ | IRWE});
        @(posedge clk);
        #1;
        set_ready(1'b0);
        @(negedge clk);
        chk("ill_decode_dut1", {18'd0, st1}, 32'd0);
        chk("ill_decode_dut2", {18'd0, st2}, {18'd0, PCWE | RET});
        @(posedge clk);
        #1;
        set_ready(1'b1);
        @(negedge clk);
        chk("nop_refetch_dut2", {18'd0, st2}, {18'd0, REQ | IRWE});
        chk("nop_count_dut2", cnt2, 32'd1);
        chk("nop_illegal_dut2", {31'd0, ill2}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("trap_strobes", {18'd0, st1}, 32'd0);
            chk("trap_illegal", {31'd0, ill1}, 32'd1);
            chk("trap_count", {28'd0, cnt1}, 32'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        do_reset();

        // 16 JALs on the 4-bit counter: 15 then wrap to 0
        for (int i = 0; i < 15; i++) run_vec(tbl[9]);
        chk("jal_count_15", {28'd0, cnt1}, 32'd15);
        run_vec(tbl[9]);
        chk("jal_count_wrap", {28'd0, cnt1}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
